// File: rtl/mspe_pkg.sv
// rtl/mspe_pkg.sv - shared types and packet-header helpers for the MSPE source side
// Purpose: FSM state type, packet length field position and an extractor for it.
// Ports: none (package).
package mspe_pkg;

    typedef enum logic [1:0] {
        ARB,
        SEND,
        DROP
    } src_sched_state_t;

    localparam int PKT_LEN_LSB = 0;
    localparam int PKT_LEN_MSB = 15;

    // Caller passes the low PKT_LEN_MSB+1 bits of the head word.
    function automatic logic [PKT_LEN_MSB-PKT_LEN_LSB:0] pkt_len(input logic [PKT_LEN_MSB:0] word);
        return word[PKT_LEN_MSB:PKT_LEN_LSB];
    endfunction

endpackage

// File: rtl/mspe_src_sched_rr_arbiter.sv
// rtl/mspe_src_sched_rr_arbiter.sv - combinational rotating-priority arbiter
// Purpose: picks the first asserted request at or after ptr, wrapping modulo N.
// Ports: req (N requests), ptr (search start), gnt_valid (any request), gnt_idx (winner).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_idx
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Walk from farthest to nearest so the candidate closest to ptr is written last and wins.
    // N is a power of two, so the index add wraps naturally.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + IW'(k);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mspe_src_sched.sv
// rtl/mspe_src_sched.sv - round-robin packet scheduler from per-core FIFOs onto the source stream
// Purpose: grants one core with a complete packet, drains it with sop/eop framing and
//          backpressure, drops malformed heads, counts sent and dropped packets.
// Ports: clk/reset (sync, active-high); enable, fifo_q, fifo_count, fifo_re (per-core FIFO side);
//        src_data/valid/sop/eop/ready (stream); busy, cur_core, pkts_sent, pkts_dropped (status).
module mspe_src_sched
    import mspe_pkg::*;
#(
    parameter int CORES         = 4,
    parameter int DATA_W        = 512,
    parameter int MAX_PKT_WORDS = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CORES-1:0]                 enable,
    input  logic [CORES-1:0][DATA_W-1:0]     fifo_q,
    input  logic [CORES-1:0][31:0]           fifo_count,
    output logic [CORES-1:0]                 fifo_re,
    output logic [DATA_W-1:0]                src_data,
    output logic                             src_valid,
    output logic                             src_sop,
    output logic                             src_eop,
    input  logic                             src_ready,
    output logic                             busy,
    output logic [$clog2(CORES)-1:0]         cur_core,
    output logic [31:0]                      pkts_sent,
    output logic [31:0]                      pkts_dropped
);
    localparam int IW = $clog2(CORES);
    localparam int LW = $clog2(MAX_PKT_WORDS) + 1;

    src_sched_state_t state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    cur_q;
    logic [LW-1:0]    len_q;
    logic [LW-1:0]    beat_q;
    logic [31:0]      sent_q;
    logic [31:0]      drop_q;

    logic [CORES-1:0] elig;
    logic [CORES-1:0] malf;
    logic [15:0]      len_v;
    logic             nz_v;
    logic             len_ok_v;
    logic             gnt_valid;
    logic [IW-1:0]    gnt_idx;

    // A core is considered only when enabled and non-empty; its head either describes a legal
    // packet (eligible once the whole packet is present) or is malformed and must be dropped.
    always_comb begin
        elig     = '0;
        malf     = '0;
        len_v    = '0;
        nz_v     = 1'b0;
        len_ok_v = 1'b0;
        for (int i = 0; i < CORES; i++) begin
            len_v    = pkt_len(fifo_q[i][PKT_LEN_MSB:0]);
            nz_v     = (fifo_count[i] != 32'd0);
            len_ok_v = (len_v != 16'd0) && (32'(len_v) <= 32'(MAX_PKT_WORDS));
            elig[i]  = enable[i] && nz_v && len_ok_v && (fifo_count[i] >= {16'd0, len_v});
            malf[i]  = enable[i] && nz_v && !len_ok_v;
        end
    end

    rr_arbiter #(.N(CORES)) u_arb (
        .req       (elig | malf),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            ptr_q   <= '0;
            cur_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            sent_q  <= '0;
            drop_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (gnt_valid) begin
                        cur_q <= gnt_idx;
                        if (elig[gnt_idx]) begin
                            // Eligible lengths never exceed MAX_PKT_WORDS, so LW bits hold them.
                            len_q   <= LW'(pkt_len(fifo_q[gnt_idx][PKT_LEN_MSB:0]));
                            beat_q  <= '0;
                            state_q <= SEND;
                        end else begin
                            state_q <= DROP;
                        end
                    end
                end
                SEND: begin
                    if (src_ready) begin
                        beat_q <= beat_q + LW'(1);
                        if (src_eop) begin
                            sent_q  <= sent_q + 32'd1;
                            ptr_q   <= cur_q + IW'(1);
                            state_q <= ARB;
                        end
                    end
                end
                DROP: begin
                    drop_q  <= drop_q + 32'd1;
                    ptr_q   <= cur_q + IW'(1);
                    state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Pop follows the accepted beat in SEND, and is a single pulse discarding the bad head in DROP.
    always_comb begin
        fifo_re = '0;
        if ((state_q == SEND && src_ready) || state_q == DROP) begin
            fifo_re[cur_q] = 1'b1;
        end
    end

    assign src_data     = fifo_q[cur_q];
    assign src_valid    = (state_q == SEND);
    assign src_sop      = (state_q == SEND) && (beat_q == '0);
    assign src_eop      = (state_q == SEND) && (beat_q == len_q - LW'(1));
    assign busy         = (state_q != ARB);
    assign cur_core     = cur_q;
    assign pkts_sent    = sent_q;
    assign pkts_dropped = drop_q;

endmodule
